// File: rtl/irq_hs_pkg.sv
// rtl/irq_hs_pkg.sv - shared state encoding and default watchdog sizing for irq_handshake_master
package irq_hs_pkg;

  typedef logic [1:0] hs_state_t;

  localparam hs_state_t IDLE  = 2'd0;
  localparam hs_state_t ISSUE = 2'd1;
  localparam hs_state_t RUN   = 2'd2;
  localparam hs_state_t ACK   = 2'd3;

  localparam int          IRQ_HS_TO_W    = 16;
  localparam int unsigned IRQ_HS_TIMEOUT = 32'h0000_FFFF;

endpackage

// File: rtl/hs_watchdog.sv
// rtl/hs_watchdog.sv - cycle watchdog for irq_handshake_master, expires at count TIMEOUT-1
module hs_watchdog #(
  parameter int          TO_W    = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  assign expired = (cnt == LAST);

  // Holds at the terminal count; the owning FSM leaves its waiting state on expiry.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/irq_handshake_master.sv
// rtl/irq_handshake_master.sv - start/ack/irq_start/irq_done initiator running N back-to-back jobs
// Optional IRQ_HS_CYCLE_CNT_EN adds last_lat, the start-to-irq_done latency of the latest run.
module irq_handshake_master
  import irq_hs_pkg::*;
#(
  parameter int          CNT_W   = 8,
  parameter int          TO_W    = IRQ_HS_TO_W,
  parameter int unsigned TIMEOUT = IRQ_HS_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_runs,
  output logic             start,
  output logic             ack,
  input  logic             irq_start,
  input  logic             irq_done,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] runs_done
`ifdef IRQ_HS_CYCLE_CNT_EN
  ,
  output logic [31:0]      last_lat
`endif
);

  hs_state_t        state;
  hs_state_t        state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             accept;
  logic             waiting;
  logic             expired;
  logic             timeout_hit;
  logic             ack_exit;
  logic             wd_clr;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign waiting     = (state == ISSUE) || (state == RUN);
  assign timeout_hit = waiting && expired;
  assign ack_exit    = (state == ACK) && !irq_done && !irq_start;
  // Clearing on every transition restarts the watchdog for each wait phase.
  assign wd_clr      = (state_nxt != state) || (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && (cmd_runs != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (expired)        state_nxt = IDLE;
        else if (irq_done)  state_nxt = ACK;
        else if (irq_start) state_nxt = RUN;
      end
      RUN: begin
        if (expired)       state_nxt = IDLE;
        else if (irq_done) state_nxt = ACK;
      end
      default: begin
        if (ack_exit) state_nxt = (remaining == CNT_W'(1)) ? IDLE : ISSUE;
      end
    endcase
  end

  hs_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start       <= 1'b0;
      ack         <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      runs_done   <= '0;
      remaining   <= '0;
    end else begin
      state <= state_nxt;
      start <= (state_nxt == ISSUE);
      ack   <= (state_nxt == ACK);
      done  <= 1'b0;
      if (accept) begin
        runs_done   <= '0;
        remaining   <= cmd_runs;
        err_timeout <= 1'b0;
        if (cmd_runs == '0) done <= 1'b1;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
        done        <= 1'b1;
      end
      if (ack_exit) begin
        runs_done <= runs_done + CNT_W'(1);
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) done <= 1'b1;
      end
    end
  end

`ifdef IRQ_HS_CYCLE_CNT_EN
  logic [31:0] lat_cnt;
  logic [31:0] lat_inc;

  assign lat_inc = (lat_cnt == 32'hFFFF_FFFF) ? lat_cnt : lat_cnt + 32'd1;

  // lat_cnt restarts on the edge that raises start; the ACK-entry edge counts too.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= '0;
      last_lat <= '0;
    end else begin
      if ((state_nxt == ISSUE) && (state != ISSUE)) begin
        lat_cnt <= '0;
      end else if (waiting) begin
        lat_cnt <= lat_inc;
      end
      if (waiting && !expired && (state_nxt == ACK)) begin
        last_lat <= lat_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_irq_handshake_master.sv
// tb/tb_irq_handshake_master.sv - directed self-checking bench for irq_handshake_master
module tb_irq_handshake_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_runs;
  logic       start;
  logic       ack;
  logic       irq_start;
  logic       irq_done;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic [7:0] runs_done;
`ifdef IRQ_HS_CYCLE_CNT_EN
  logic [31:0] last_lat;
`endif

  int checks   = 0;
  int failures = 0;
  int start_rises = 0;
  logic start_q = 1'b0;

  typedef struct {
    logic [7:0] runs;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  irq_handshake_master #(
    .CNT_W   (8),
    .TO_W    (16),
    .TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_runs    (cmd_runs),
    .start       (start),
    .ack         (ack),
    .irq_start   (irq_start),
    .irq_done    (irq_done),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .runs_done   (runs_done)
`ifdef IRQ_HS_CYCLE_CNT_EN
    ,
    .last_lat    (last_lat)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Every done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (start === 1'b1 && start_q !== 1'b1) start_rises++;
    start_q <= start;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_runs_done", {24'd0, runs_done}, {24'd0, e.runs});
        check("done_err_timeout", {31'd0, err_timeout}, {31'd0, e.err});
      end
    end
  end

  task automatic send(input logic [7:0] runs, input bit expect_done,
                      input logic [7:0] exp_rd, input logic exp_err);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_runs  = runs;
    if (expect_done) sb.push_back('{runs: exp_rd, err: exp_err});
    tick;
    cmd_valid = 1'b0;
  endtask

  // Entered with start just raised; leaves right after the irq_done fall edge.
  task automatic serve(input int d_start, input int d_done, input bit last, input int idx);
    check("start_rise", {31'd0, start}, 32'd1);
    repeat (d_start - 1) tick;
    irq_start = 1'b1;
    tick;
    irq_start = 1'b0;
    check("start_drop", {31'd0, start}, 32'd0);
    repeat (d_done - 1) tick;
    irq_done = 1'b1;
    tick;
    check("ack_rise", {31'd0, ack}, 32'd1);
    tick;
    check("ack_hold", {31'd0, ack}, 32'd1);
    irq_done = 1'b0;
    tick;
    check("ack_fall", {31'd0, ack}, 32'd0);
    check("runs_done_step", {24'd0, runs_done}, idx);
    if (last) begin
      check("busy_after", {31'd0, busy}, 32'd0);
      check("start_after", {31'd0, start}, 32'd0);
    end else begin
      check("next_start", {31'd0, start}, 32'd1);
    end
  endtask

  initial begin
    int r0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_runs  = '0;
    irq_start = 1'b0;
    irq_done  = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);
    check("rst_runs_done", {24'd0, runs_done}, 32'd0);

    // single run
    r0 = start_rises;
    send(8'd1, 1'b1, 8'd1, 1'b0);
    serve(2, 10, 1'b1, 1);
    tick;
    check("single_start_count", start_rises - r0, 32'd1);

    // three runs, with a command attempt during run 2 that must be ignored
    send(8'd3, 1'b1, 8'd3, 1'b0);
    serve(2, 4, 1'b0, 1);
    cmd_valid = 1'b1;
    cmd_runs  = 8'd5;
    check("busy_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    serve(3, 2, 1'b0, 2);
    cmd_valid = 1'b0;
    serve(1, 6, 1'b1, 3);
    tick;

    // timeout with irq_start never raised
    send(8'd1, 1'b1, 8'd0, 1'b1);
    check("to_start", {31'd0, start}, 32'd1);
    repeat (19) tick;
    check("to_err_early", {31'd0, err_timeout}, 32'd0);
    check("to_start_early", {31'd0, start}, 32'd1);
    tick;
    check("to_err", {31'd0, err_timeout}, 32'd1);
    check("to_start_drop", {31'd0, start}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    tick;
    check("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // zero runs, also clears err_timeout
    r0 = start_rises;
    send(8'd0, 1'b1, 8'd0, 1'b0);
    check("zero_err_clr", {31'd0, err_timeout}, 32'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick;
    check("zero_no_start", start_rises - r0, 32'd0);

    // reset during run 2 of 4
    send(8'd4, 1'b0, 8'd0, 1'b0);
    serve(2, 5, 1'b0, 1);
    tick;
    irq_start = 1'b1;
    tick;
    irq_start = 1'b0;
    repeat (3) tick;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_start", {31'd0, start}, 32'd0);
    check("mrst_ack", {31'd0, ack}, 32'd0);
    check("mrst_runs_done", {24'd0, runs_done}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    tick;
    check("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mrst_start_low", {31'd0, start}, 32'd0);

    // irq_done arrives while still in ISSUE
    send(8'd1, 1'b1, 8'd1, 1'b0);
    repeat (3) tick;
    irq_done = 1'b1;
    tick;
    check("miss_ack", {31'd0, ack}, 32'd1);
    check("miss_start_drop", {31'd0, start}, 32'd0);
`ifdef IRQ_HS_CYCLE_CNT_EN
    check("miss_last_lat", last_lat, 32'd4);
`endif
    irq_done = 1'b0;
    tick;
    check("miss_runs_done", {24'd0, runs_done}, 32'd1);
    check("miss_busy", {31'd0, busy}, 32'd0);

    repeat (3) tick;
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/irq_handshake_master.md
Name: irq_handshake_master

Overview:
- Initiator side of the start/ack/irqStart/irqDone handshake used by the team's counter and accelerator peripherals.
- Accepts a command for N back-to-back runs and drives start to the peripheral.
- Waits for irqStart, then irqDone; acknowledges each completion and moves to the next run.
- Sits between the AXI-lite control registers and the peripheral, so software need not service per-run interrupts.

Parameters:
- CNT_W, 8, width of the run-count field; max runs per command = 2^CNT_W-1.
- TO_W, 16, width of the watchdog counter.
- TIMEOUT, 16'hFFFF, cycles allowed in ISSUE or RUN before abort; must fit in TO_W.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_runs  in  CNT_W  number of runs; sampled on cmd_valid&&cmd_ready.
- start  out  1  to peripheral start.
- ack  out  1  to peripheral ack.
- irq_start  in  1  peripheral started.
- irq_done  in  1  peripheral finished.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at command completion.
- err_timeout  out  1  sticky; cleared on next accepted command.
- runs_done  out  CNT_W  completed runs in current/last command.

Behaviour:
- Reset: state IDLE; start=0, ack=0, done=0, err_timeout=0, runs_done=0, internal remaining=0, watchdog=0. cmd_ready=1 the cycle after reset deasserts. Reset mid-run drops start/ack immediately (registered, next edge).
- All outputs registered except cmd_ready and busy, which decode state.
- IDLE: on cmd_valid&&cmd_ready:
  - cmd_runs==0: stay IDLE, pulse done next cycle, runs_done=0, err_timeout cleared.
  - else: latch remaining=cmd_runs, runs_done=0, clear err_timeout, go ISSUE.
- ISSUE: start=1.
  - irq_start=1 -> RUN; start=0 from the same edge.
  - irq_done=1 seen while in ISSUE (irq_start missed) -> ACK directly.
- RUN: start=0, wait irq_done=1 -> ACK.
- ACK: ack=1 while irq_done=1. When irq_done=0 (and irq_start=0):
  - ack=0; runs_done+=1; remaining-=1.
  - remaining==1 before decrement -> IDLE with done pulse (registered, same edge as IDLE entry).
  - else -> ISSUE.
- Latency:
  - cmd accept -> start=1: 1 cycle.
  - irq_done rise -> ack=1: 1 cycle.
  - irq_done fall -> next start=1: 1 cycle.
- Watchdog: reset to 0 on every state entry; increments in ISSUE and RUN only. At watchdog==TIMEOUT-1:
  - err_timeout=1, start=0, ack=0, done pulse.
  - runs_done holds the completed count; go IDLE.
- No watchdog in ACK: peripheral must release irq_done.
- runs_done saturates by construction (≤cmd_runs) and never wraps.
- cmd_valid outside IDLE is ignored (cmd_ready=0); no queuing.
- Simultaneous irq_start and irq_done in ISSUE -> ACK (done dominates).

Optional Feature:
- Macro: IRQ_HS_CYCLE_CNT_EN.
- Defined:
  - Adds output last_lat [31:0]: cycles from start rise to irq_done rise for the most recent run.
  - Updated on entry to ACK; reset 0; saturates at 32'hFFFFFFFF.
  - Not updated on timeout.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package irq_hs_pkg:
  - state typedef {IDLE, ISSUE, RUN, ACK} (2-bit encoding).
  - default TO_W and TIMEOUT constants.
- Sub-module hs_watchdog:
  - Inputs: clk, rst, clr, en.
  - Output: expired at count TIMEOUT-1.
  - Parameters: TO_W, TIMEOUT.
- FSM and counters remain in the top.

Test Plan:
- Single run: cmd_runs=1, peripheral model raises irq_start 2 cycles after start, irq_done 10 cycles later, drops irq_done 1 cycle after ack -> exactly one start pulse, ack high while irq_done high, done pulse, runs_done=1, busy low after.
- Multi-run: cmd_runs=3 -> three start/ack cycles, each start 1 cycle after irq_done falls; runs_done steps 1,2,3; single done pulse after third ack.
- Timeout: TIMEOUT=20, peripheral never raises irq_start -> start low, err_timeout=1 and done pulse at cycle 20 after entering ISSUE; runs_done=0; next command clears err_timeout.
- Zero runs: cmd_runs=0 -> start never asserted, done pulse 1 cycle after accept, runs_done=0.
- Reset mid-RUN: assert rst for 1 cycle during run 2 of 4 -> start=ack=0, runs_done=0, IDLE, cmd_ready=1 after reset.
- Missed irq_start: irq_done rises while in ISSUE with irq_start=0 -> ACK entered, ack=1 next cycle, run counted; with IRQ_HS_CYCLE_CNT_EN, last_lat equals the start-to-irq_done cycle count.
